// File: rtl/h_dmux4_dispatcher_pkg.sv
// Shared definitions for the 4-way demux dispatcher.
//   state_e : dispatcher states (StIdle = empty, StHold = word held)
//   mode_e  : per-word routing mode (ModeRr = round-robin, ModeDir = directed)
package h_dmux4_dispatcher_pkg;

  localparam int unsigned NumChan = 4;
  localparam int unsigned SelW    = 2;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StHold = 1'b1
  } state_e;

  typedef enum logic [0:0] {
    ModeRr  = 1'b0,
    ModeDir = 1'b1
  } mode_e;

endpackage

// File: rtl/h_dmux4_dispatcher_rr_pick4.sv
// Combinational cyclic picker over four channels.
//   mask_i  : eligibility mask, bit i = channel i
//   start_i : first channel to consider; search wraps 3 -> 0
//   idx_o   : first eligible channel at/after start_i (start_i when none)
//   found_o : 1 when any channel is eligible
module h_dmux4_dispatcher_rr_pick4
  import h_dmux4_dispatcher_pkg::*;
(
  input  logic [NumChan-1:0] mask_i,
  input  logic [SelW-1:0]    start_i,
  output logic [SelW-1:0]    idx_o,
  output logic               found_o
);

  // Walk offsets from farthest to nearest so the nearest eligible channel wins.
  always_comb begin
    idx_o   = start_i;
    found_o = 1'b0;
    for (int k = NumChan - 1; k >= 0; k--) begin
      if (mask_i[start_i + SelW'(k)]) begin
        idx_o   = start_i + SelW'(k);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/h_dmux4_dispatcher.sv
// Select sequencer for a 4-way demultiplexer with a one-word holding register.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_data/in_dest     : input word and its target channel (directed mode only)
//   in_valid/in_ready   : input handshake; accept = in_valid & in_ready
//   mode                : 0 round-robin over chan_en, 1 directed by in_dest; sampled at accept
//   chan_en             : round-robin eligibility mask
//   sel                 : channel currently driven
//   out_data            : held word, shared by all channels
//   out_valid/out_ready : one-hot valid on sel, per-channel sink ready
//   busy                : a word is held
//   skip                : one-cycle pulse when a stalled round-robin word is re-targeted
module h_dmux4_dispatcher
  import h_dmux4_dispatcher_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SelW-1:0]    in_dest,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mode,
  input  logic [NumChan-1:0] chan_en,
  output logic [SelW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [NumChan-1:0] out_valid,
  input  logic [NumChan-1:0] out_ready,
  output logic               busy,
  output logic               skip
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [SelW-1:0]   sel_q, sel_d;
  logic [SelW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              skip_q, skip_d;

  logic              hold;
  logic              xfer;
  logic              accept;
  logic [SelW-1:0]   pick_start;
  logic [SelW-1:0]   acc_idx;
  logic              acc_found;
  logic [SelW-1:0]   to_idx;
  logic              to_found;

  assign hold = (state_q == StHold);
  assign xfer = hold & out_ready[sel_q];

  // On a same-cycle transfer the pointer is about to become sel+1; pick from there.
  assign pick_start = xfer ? (sel_q + 2'd1) : rr_ptr_q;

  h_dmux4_dispatcher_rr_pick4 u_pick_accept (
    .mask_i  (chan_en),
    .start_i (pick_start),
    .idx_o   (acc_idx),
    .found_o (acc_found)
  );

  // Searching from sel+1 visits sel last, so sel is only kept when it is the sole choice.
  h_dmux4_dispatcher_rr_pick4 u_pick_timeout (
    .mask_i  (chan_en),
    .start_i (sel_q + 2'd1),
    .idx_o   (to_idx),
    .found_o (to_found)
  );

  // acc_found is simply |chan_en; round-robin needs at least one eligible channel.
  assign in_ready = hold ? (out_ready[sel_q] & (mode | acc_found)) : (mode | acc_found);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    skip_d   = 1'b0;

    if (xfer) begin
      rr_ptr_d = sel_q + 2'd1;
      cnt_d    = '0;
      state_d  = StIdle;
    end

    if (accept) begin
      state_d = StHold;
      mode_d  = mode_e'(mode);
      data_d  = in_data;
      sel_d   = mode ? in_dest : acc_idx;
      cnt_d   = '0;
    end else if (hold && !xfer && (mode_q == ModeRr) && (TIMEOUT > 0)) begin
      // The TIMEOUT-th stalled cycle re-targets; the counter never rests at TIMEOUT.
      if (cnt_q == CntW'(TIMEOUT - 1)) begin
        cnt_d = '0;
        if (to_found) begin
          sel_d  = to_idx;
          skip_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mode_q   <= ModeRr;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      skip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      skip_q   <= skip_d;
    end
  end

  assign sel       = sel_q;
  assign out_data  = data_q;
  assign busy      = hold;
  assign skip      = skip_q;
  assign out_valid = hold ? (4'b0001 << sel_q) : 4'b0000;

endmodule

// File: tb/tb_h_dmux4_dispatcher.sv
// Self-checking bench for h_dmux4_dispatcher: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the dispatch rules.
module tb_h_dmux4_dispatcher;

  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_dest;
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [3:0]       chan_en;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic             busy;
  logic             skip;

  always #5 clk = ~clk;

  h_dmux4_dispatcher #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .chan_en   (chan_en),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .skip      (skip)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit               m_held;
  logic [WIDTH-1:0] m_data;
  int               m_sel;
  int               m_rr;
  int               m_stall;
  bit               m_dir;
  bit               m_skip;

  logic [WIDTH-1:0] words [5] = '{16'hA001, 16'hB002, 16'hC003, 16'hD004, 16'hE005};
  int               t3_chan [3] = '{1, 3, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input int s);
    logic [3:0] r;
    r = 4'b0001 << s;
    return r;
  endfunction

  // First enabled channel at or after start, cyclic; -1 when none.
  function automatic int next_en(input logic [3:0] m, input int start);
    for (int k = 0; k < 4; k++) begin
      if (m[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  function automatic bit m_in_ready();
    bit rr_ok;
    rr_ok = (chan_en != 4'b0000);
    if (!m_held) return mode || rr_ok;
    return out_ready[m_sel] && (mode || rr_ok);
  endfunction

  task automatic model_reset();
    m_held  = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_rr    = 0;
    m_stall = 0;
    m_dir   = 1'b0;
    m_skip  = 1'b0;
  endtask

  task automatic model_step();
    bit ir;
    bit xfer;
    bit acc;
    ir     = m_in_ready();
    xfer   = m_held && out_ready[m_sel];
    acc    = in_valid && ir;
    m_skip = 1'b0;
    if (xfer) begin
      m_rr    = (m_sel + 1) % 4;
      m_stall = 0;
      m_held  = 1'b0;
    end
    if (acc) begin
      m_held  = 1'b1;
      m_data  = in_data;
      m_dir   = mode;
      m_sel   = mode ? int'(in_dest) : next_en(chan_en, m_rr);
      m_stall = 0;
    end else if (m_held && !m_dir && TIMEOUT > 0) begin
      m_stall++;
      if (m_stall == TIMEOUT) begin
        m_stall = 0;
        if (chan_en != 4'b0000) begin
          m_sel  = next_en(chan_en, (m_sel + 1) % 4);
          m_skip = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("in_ready", 32'(in_ready), 32'(m_in_ready()));
    chk("busy", 32'(busy), 32'(m_held));
    chk("out_valid", 32'(out_valid), 32'(m_held ? onehot(m_sel) : 4'b0000));
    chk("sel", 32'(sel), 32'(m_sel));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("skip", 32'(skip), 32'(m_skip));
  endtask

  // Inputs are set by the caller at posedge+1; compare, advance the model, cross one edge.
  task automatic tick();
    #1;
    compare_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_dest   = 2'd0;
    in_valid  = 1'b0;
    mode      = 1'b0;
    chan_en   = 4'b0000;
    out_ready = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_skip", 32'(skip), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;

    // Asynchronous reset while a directed word is held
    mode = 1'b1; in_dest = 2'd3; in_data = 16'h1234; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t1_busy_held", 32'(busy), 32'd1);
    chk("t1_valid_held", 32'(out_valid), 32'b1000);
    rst_n = 1'b0;
    #1;
    chk("t1_async_valid", 32'(out_valid), 32'd0);
    chk("t1_async_busy", 32'(busy), 32'd0);
    chk("t1_async_sel", 32'(sel), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin over all channels, back-to-back
    mode = 1'b0; chan_en = 4'hF; out_ready = 4'hF;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = words[i];
      tick();
      chk("t2_valid", 32'(out_valid), 32'(onehot(i % 4)));
      chk("t2_data", 32'(out_data), 32'(words[i]));
      chk("t2_busy", 32'(busy), 32'd1);
      chk("t2_in_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("t2_drained", 32'(busy), 32'd0);

    // Sparse mask, then empty mask
    chan_en = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h3000 + 16'(i);
      tick();
      chk("t3_valid", 32'(out_valid), 32'(onehot(t3_chan[i])));
    end
    in_valid = 1'b0;
    tick();
    chan_en  = 4'b0000;
    in_valid = 1'b1;
    tick();
    chk("t3_no_ready", 32'(in_ready), 32'd0);
    chk("t3_no_accept", 32'(busy), 32'd0);

    // Directed word stalls indefinitely, then releases
    chan_en = 4'hF; mode = 1'b1; in_dest = 2'd2; out_ready = 4'b1011; in_data = 16'hD00D;
    tick();
    in_valid = 1'b0;
    in_data  = 16'hFFFF;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t4_valid", 32'(out_valid), 32'b0100);
      chk("t4_skip", 32'(skip), 32'd0);
      chk("t4_data", 32'(out_data), 32'hD00D);
    end
    out_ready = 4'hF;
    tick();
    chk("t4_released", 32'(busy), 32'd0);
    mode = 1'b0; in_valid = 1'b1; in_data = 16'h0303;
    tick();
    chk("t4_rr_ptr3", 32'(out_valid), 32'b1000);
    in_valid = 1'b0;
    tick();

    // Round-robin word times out on channel 0 and moves to channel 1
    chan_en = 4'b0011; out_ready = 4'b1110; in_data = 16'h5A5A; in_valid = 1'b1;
    tick();
    chk("t5_start", 32'(out_valid), 32'b0001);
    in_valid = 1'b0;
    repeat (7) tick();
    chk("t5_still0", 32'(out_valid), 32'b0001);
    chk("t5_noskip", 32'(skip), 32'd0);
    tick();
    chk("t5_skip", 32'(skip), 32'd1);
    chk("t5_sel", 32'(sel), 32'd1);
    chk("t5_valid", 32'(out_valid), 32'b0010);
    chk("t5_data", 32'(out_data), 32'h5A5A);
    tick();
    chk("t5_delivered", 32'(busy), 32'd0);
    chk("t5_skip_done", 32'(skip), 32'd0);

    // Random traffic with periodic sink stalls to provoke timeouts
    for (int i = 0; i < 600; i++) begin
      if (i % 16 == 0) chan_en = 4'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      mode     = ($urandom_range(0, 3) == 0);
      in_dest  = 2'($urandom);
      in_data  = 16'($urandom);
      if ((i / 40) % 3 == 2) out_ready = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      else                   out_ready = 4'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
